// File: rtl/freoff_seq_ctrl.sv
// Frame sequencer for the frequency-offset estimate/compensate stage: enable, estimation wait,
// strobe gating per OFDM symbol and pipeline drain. Optional counters under FREOFF_SEQ_STATS_EN.
module freoff_seq_ctrl #(
  parameter int SYM_LEN     = 320,
  parameter int EST_TIMEOUT = 64,
  parameter int DRAIN_CYC   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       pkt_det,
  input  logic [7:0] num_sym,
  input  logic       est_rdy,
  input  logic       stb_in,
  output logic       fo_ena,
  output logic       fo_stb,
  output logic       sym_start,
  output logic [7:0] sym_idx,
  output logic       busy,
  output logic       frame_done,
  output logic       est_timeout
`ifdef FREOFF_SEQ_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] tmo_cnt
`endif
);

  localparam int SW = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam int TW = (EST_TIMEOUT > 1) ? $clog2(EST_TIMEOUT) : 1;
  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [SW-1:0] SAMP_LAST  = SW'(SYM_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(EST_TIMEOUT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT_EST, RUN, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    idx_q, idx_d;
  logic [SW-1:0] samp_q, samp_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          ena_q, ena_d;
  logic          sym_start_q, sym_start_d;
  logic          frame_done_q, frame_done_d;
  logic          est_timeout_q, est_timeout_d;

  assign fo_stb = stb_in & ce & (state_q == RUN);

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    idx_d         = idx_q;
    samp_d        = samp_q;
    wait_d        = wait_q;
    drain_d       = drain_q;
    sym_start_d   = 1'b0;
    frame_done_d  = 1'b0;
    est_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_det) begin
          state_d = WAIT_EST;
          // last_q holds the index of the final symbol, so a zero count collapses to one symbol
          last_d  = (num_sym == 8'd0) ? 8'd0 : num_sym - 8'd1;
          idx_d   = 8'd0;
          samp_d  = '0;
          wait_d  = '0;
          drain_d = '0;
        end
      end
      WAIT_EST: begin
        if (est_rdy) begin
          state_d = RUN;
        end else if (wait_q == TMO_LAST) begin
          state_d       = IDLE;
          est_timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      RUN: begin
        if (fo_stb) begin
          sym_start_d = (samp_q == '0);
          if (samp_q == SAMP_LAST) begin
            samp_d = '0;
            if (idx_q == last_q) begin
              state_d = DRAIN;
            end else begin
              idx_d = idx_q + 8'd1;
            end
          end else begin
            samp_d = samp_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
          idx_d        = 8'd0;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ena_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= 8'd0;
      idx_q         <= 8'd0;
      samp_q        <= '0;
      wait_q        <= '0;
      drain_q       <= '0;
      ena_q         <= 1'b0;
      sym_start_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      est_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      idx_q         <= idx_d;
      samp_q        <= samp_d;
      wait_q        <= wait_d;
      drain_q       <= drain_d;
      ena_q         <= ena_d;
      sym_start_q   <= sym_start_d;
      frame_done_q  <= frame_done_d;
      est_timeout_q <= est_timeout_d;
    end
  end

  // The stage enable is high in every non-IDLE state, so busy shares its register
  assign fo_ena      = ena_q;
  assign busy        = ena_q;
  assign sym_start   = sym_start_q;
  assign sym_idx     = idx_q;
  assign frame_done  = frame_done_q;
  assign est_timeout = est_timeout_q;

`ifdef FREOFF_SEQ_STATS_EN
  logic [15:0] frame_cnt_q, tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      tmo_cnt_q   <= 16'd0;
    end else begin
      if (frame_done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (est_timeout_d && (tmo_cnt_q != 16'hFFFF)) tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign tmo_cnt   = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_freoff_seq_ctrl.sv
// Self-checking bench for freoff_seq_ctrl: scoreboard of expected gated strobes plus per-scenario checks.
module tb_freoff_seq_ctrl;
  localparam int SYM_LEN   = 320;
  localparam int DRAIN_CYC = 32;

  logic       clk, rst, ce, pkt_det, est_rdy, stb_in;
  logic [7:0] num_sym;
  logic       fo_ena, fo_stb, sym_start, busy, frame_done, est_timeout;
  logic [7:0] sym_idx;
`ifdef FREOFF_SEQ_STATS_EN
  logic [15:0] frame_cnt, tmo_cnt;
`endif

  freoff_seq_ctrl #(.SYM_LEN(SYM_LEN), .EST_TIMEOUT(64), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .ce(ce), .pkt_det(pkt_det), .num_sym(num_sym),
    .est_rdy(est_rdy), .stb_in(stb_in), .fo_ena(fo_ena), .fo_stb(fo_stb),
    .sym_start(sym_start), .sym_idx(sym_idx), .busy(busy),
`ifdef FREOFF_SEQ_STATS_EN
    .frame_cnt(frame_cnt), .tmo_cnt(tmo_cnt),
`endif
    .frame_done(frame_done), .est_timeout(est_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic ss; logic [7:0] idx;} exp_t;
  exp_t sb_q[$];

  int n_tests = 0, n_fail = 0;
  int cyc_n = 0, stb_cnt = 0, ss_cnt = 0, fd_cnt = 0, to_cnt = 0, sb_bad = 0;
  int last_stb_cyc = 0, fd_cyc = 0, to_cyc = 0, rise_cyc = 0;
  logic in_run = 1'b0;
  int k = 0, run_total = 0;

  // Monitor: pops one expectation per observed fo_stb and checks sym_start on the following cycle
  initial begin
    exp_t e;
    logic pend_v, pend_ss, ena_prev;
    pend_v = 1'b0; pend_ss = 1'b0; ena_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (sym_start !== (pend_v ? pend_ss : 1'b0)) sb_bad++;
      pend_v = 1'b0;
      if (fo_stb === 1'b1) begin
        stb_cnt++;
        last_stb_cyc = cyc_n;
        if (sb_q.size() == 0) sb_bad++;
        else begin
          e = sb_q.pop_front();
          if (sym_idx !== e.idx) sb_bad++;
          pend_v  = (rst !== 1'b1);
          pend_ss = e.ss;
        end
      end
      if (sym_start === 1'b1) ss_cnt++;
      if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc_n; end
      if (est_timeout === 1'b1) begin to_cnt++; to_cyc = cyc_n; end
      if (fo_ena === 1'b1 && !ena_prev) rise_cyc = cyc_n;
      ena_prev = (fo_ena === 1'b1);
    end
  end

  // One clock of stimulus; pushes the expectation for every strobe that should pass the gate
  task automatic cyc(input logic p, input logic [7:0] ns, input logic er,
                     input logic s, input logic c, input logic r);
    @(posedge clk); #1;
    rst = r; pkt_det = p; num_sym = ns; est_rdy = er; stb_in = s; ce = c;
    if (in_run && s && c) begin
      sb_q.push_back('{ss: ((k % SYM_LEN) == 0), idx: 8'(k / SYM_LEN)});
      k++;
      if (k == run_total) in_run = 1'b0;
    end
    @(negedge clk); #1;
  endtask

  // pkt_det, then est_rdy d cycles later; strobes are offered throughout
  task automatic start_frame(input logic [7:0] ns, input int d);
    cyc(1'b1, ns, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i < d; i++) cyc(1'b0, ns, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, ns, 1'b1, 1'b1, 1'b1, 1'b0);
    in_run = 1'b1; k = 0;
    run_total = ((ns == 8'd0) ? 1 : int'(ns)) * SYM_LEN;
  endtask

  task automatic run_full(input logic [7:0] ns);
    for (int i = 0; i < 3000 && in_run; i++) cyc(1'b0, ns, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain_wait(input logic [7:0] ns);
    int f0 = fd_cnt;
    for (int i = 0; i < 200 && fd_cnt == f0; i++) cyc(1'b0, ns, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (fo_ena !== 1'b0) begin n_fail++; $display("FAIL reset_fo_ena got %b want 0", fo_ena); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (fo_stb !== 1'b0) begin n_fail++; $display("FAIL reset_fo_stb got %b want 0", fo_stb); end
    n_tests++; if ({sym_start, frame_done, est_timeout, sym_idx} !== 11'd0) begin
      n_fail++; $display("FAIL reset_pulses got %b/%b/%b idx %0d want 0", sym_start, frame_done, est_timeout, sym_idx); end
`ifdef FREOFF_SEQ_STATS_EN
    n_tests++; if ({frame_cnt, tmo_cnt} !== 32'd0) begin
      n_fail++; $display("FAIL reset_stats got %0d/%0d want 0/0", frame_cnt, tmo_cnt); end
`endif
    $display("[TB] reset done");
  endtask

  task automatic test_nominal();
    int s0 = stb_cnt, ss0 = ss_cnt, f0 = fd_cnt, b0 = sb_bad;
    start_frame(8'd2, 20);
    n_tests++; if (fo_ena !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL nom_wait_ena got %b/%b want 1/1", fo_ena, busy); end
    run_full(8'd2);
    cyc(1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (sym_idx !== 8'd1 || fo_ena !== 1'b1) begin
      n_fail++; $display("FAIL nom_drain_hold got idx %0d ena %b want 1/1", sym_idx, fo_ena); end
    drain_wait(8'd2);
    n_tests++; if (stb_cnt - s0 !== 640) begin n_fail++; $display("FAIL nom_stb_count got %0d want 640", stb_cnt - s0); end
    n_tests++; if (ss_cnt - ss0 !== 2) begin n_fail++; $display("FAIL nom_sym_start got %0d want 2", ss_cnt - ss0); end
    n_tests++; if (sb_bad - b0 !== 0 || sb_q.size() !== 0) begin
      n_fail++; $display("FAIL nom_scoreboard got %0d errors %0d left want 0/0", sb_bad - b0, sb_q.size()); end
    n_tests++; if (fd_cnt - f0 !== 1 || fd_cyc - last_stb_cyc !== DRAIN_CYC + 1) begin
      n_fail++; $display("FAIL nom_done_timing got %0d pulses gap %0d want 1/%0d", fd_cnt - f0, fd_cyc - last_stb_cyc, DRAIN_CYC + 1); end
    n_tests++; if (fo_ena !== 1'b0 || busy !== 1'b0 || sym_idx !== 8'd0) begin
      n_fail++; $display("FAIL nom_end_state got ena %b busy %b idx %0d want 0/0/0", fo_ena, busy, sym_idx); end
    $display("[TB] nominal frame: %0d strobes", stb_cnt - s0);
  endtask

  task automatic test_timeout();
    int s0 = stb_cnt, t0 = to_cnt, b0 = sb_bad;
    cyc(1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 100 && to_cnt == t0; i++) cyc(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (to_cyc - rise_cyc !== 64) begin n_fail++; $display("FAIL tmo_delay got %0d want 64", to_cyc - rise_cyc); end
    n_tests++; if (fo_ena !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_ena got %b/%b want 0/0", fo_ena, busy); end
    cyc(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (to_cnt - t0 !== 1 || est_timeout !== 1'b0) begin
      n_fail++; $display("FAIL tmo_pulse got %0d pulses level %b want 1/0", to_cnt - t0, est_timeout); end
    n_tests++; if (stb_cnt - s0 !== 0 || sb_bad - b0 !== 0) begin
      n_fail++; $display("FAIL tmo_no_stb got %0d strobes want 0", stb_cnt - s0); end
    $display("[TB] timeout frame: pulse %0d cycles after enable", to_cyc - rise_cyc);
  endtask

  task automatic test_race();
    int s0 = stb_cnt, t0 = to_cnt, f0 = fd_cnt, b0 = sb_bad;
    start_frame(8'd1, 64);
    n_tests++; if (fo_ena !== 1'b1 || est_timeout !== 1'b0) begin
      n_fail++; $display("FAIL race_run got ena %b tmo %b want 1/0", fo_ena, est_timeout); end
    run_full(8'd1);
    drain_wait(8'd1);
    n_tests++; if (to_cnt - t0 !== 0) begin n_fail++; $display("FAIL race_no_tmo got %0d pulses want 0", to_cnt - t0); end
    n_tests++; if (stb_cnt - s0 !== 320 || fd_cnt - f0 !== 1 || sb_bad - b0 !== 0) begin
      n_fail++; $display("FAIL race_frame got %0d strobes %0d done %0d errors want 320/1/0", stb_cnt - s0, fd_cnt - f0, sb_bad - b0); end
    $display("[TB] race frame: %0d strobes", stb_cnt - s0);
  endtask

  task automatic test_gaps();
    int s0 = stb_cnt, ss0 = ss_cnt, f0 = fd_cnt, b0 = sb_bad;
    start_frame(8'd1, 5);
    for (int i = 0; i < 4000 && in_run; i++)
      cyc(1'b0, 8'd1, 1'b0, (i % 3) == 0, (i % 2) == 0, 1'b0);
    drain_wait(8'd1);
    n_tests++; if (stb_cnt - s0 !== 320) begin n_fail++; $display("FAIL gaps_stb_count got %0d want 320", stb_cnt - s0); end
    n_tests++; if (sb_bad - b0 !== 0 || sb_q.size() !== 0 || ss_cnt - ss0 !== 1) begin
      n_fail++; $display("FAIL gaps_scoreboard got %0d errors %0d left %0d starts want 0/0/1", sb_bad - b0, sb_q.size(), ss_cnt - ss0); end
    n_tests++; if (fd_cnt - f0 !== 1) begin n_fail++; $display("FAIL gaps_done got %0d want 1", fd_cnt - f0); end
    $display("[TB] gapped frame: %0d strobes", stb_cnt - s0);
  endtask

  task automatic test_ignored_and_reset();
    int s0 = stb_cnt, f0, t0, b0 = sb_bad;
    start_frame(8'd1, 3);
    for (int i = 0; i < 100; i++) cyc(1'b0, 8'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 8'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    run_full(8'd5);
    f0 = fd_cnt;
    drain_wait(8'd5);
    n_tests++; if (stb_cnt - s0 !== 320 || fd_cnt - f0 !== 1 || sb_bad - b0 !== 0) begin
      n_fail++; $display("FAIL ignore_pkt got %0d strobes %0d done %0d errors want 320/1/0", stb_cnt - s0, fd_cnt - f0, sb_bad - b0); end
    start_frame(8'd2, 3);
    for (int i = 0; i < 50; i++) cyc(1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    f0 = fd_cnt; t0 = to_cnt;
    cyc(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    in_run = 1'b0;
    cyc(1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if ({fo_ena, busy, fo_stb, sym_start, frame_done, est_timeout, sym_idx} !== 14'd0) begin
      n_fail++; $display("FAIL mid_reset got ena %b busy %b stb %b idx %0d want all 0", fo_ena, busy, fo_stb, sym_idx); end
    for (int i = 0; i < 40; i++) cyc(1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    n_tests++; if (fd_cnt - f0 !== 0 || to_cnt - t0 !== 0 || sb_q.size() !== 0) begin
      n_fail++; $display("FAIL mid_reset_quiet got %0d done %0d tmo %0d left want 0/0/0", fd_cnt - f0, to_cnt - t0, sb_q.size()); end
    $display("[TB] ignored start and mid-frame reset done");
  endtask

  task automatic test_numsym0();
    int s0 = stb_cnt, ss0 = ss_cnt, f0 = fd_cnt, b0 = sb_bad;
    start_frame(8'd0, 4);
    run_full(8'd0);
    drain_wait(8'd0);
    n_tests++; if (stb_cnt - s0 !== 320 || ss_cnt - ss0 !== 1) begin
      n_fail++; $display("FAIL numsym0_count got %0d strobes %0d starts want 320/1", stb_cnt - s0, ss_cnt - ss0); end
    n_tests++; if (fd_cnt - f0 !== 1 || sb_bad - b0 !== 0) begin
      n_fail++; $display("FAIL numsym0_done got %0d done %0d errors want 1/0", fd_cnt - f0, sb_bad - b0); end
    $display("[TB] num_sym=0 frame: %0d strobes", stb_cnt - s0);
  endtask

  initial begin
    rst = 1'b1; pkt_det = 1'b0; num_sym = 8'd0; est_rdy = 1'b0; stb_in = 1'b0; ce = 1'b0;
    test_reset();
    test_nominal();
    test_timeout();
`ifdef FREOFF_SEQ_STATS_EN
    n_tests++; if (frame_cnt !== 16'd1 || tmo_cnt !== 16'd1) begin
      n_fail++; $display("FAIL stats got %0d/%0d want 1/1", frame_cnt, tmo_cnt); end
`endif
    test_race();
    test_gaps();
    test_ignored_and_reset();
    test_numsym0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
